// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the memory-stage load/store unit: instruction
//   size/sign codes (instrM[28:26]), bus data_size encodings, the FSM state
//   type and small decode helpers used by both the top and load_extend.
package mem_access_unit_pkg;

  // Size/sign codes carried in instrM[28:26]
  localparam logic [2:0] SZ_LB  = 3'b000;
  localparam logic [2:0] SZ_LH  = 3'b001;
  localparam logic [2:0] SZ_LW  = 3'b011;
  localparam logic [2:0] SZ_LBU = 3'b100;
  localparam logic [2:0] SZ_LHU = 3'b101;

  // data_size encodings on the bus
  localparam logic [1:0] BUS_BYTE = 2'd0;
  localparam logic [1:0] BUS_HALF = 2'd1;
  localparam logic [1:0] BUS_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsuStateT;

  // Loads accept signed and unsigned byte/half codes; stores only know the
  // signed encodings. Anything unrecognised is treated as a word access.
  function automatic logic [1:0] busSize(input logic [2:0] code, input logic isStore);
    logic [1:0] sz;
    sz = BUS_WORD;
    if (isStore) begin
      case (code)
        SZ_LB:   sz = BUS_BYTE;
        SZ_LH:   sz = BUS_HALF;
        default: sz = BUS_WORD;
      endcase
    end else begin
      case (code)
        SZ_LB, SZ_LBU: sz = BUS_BYTE;
        SZ_LH, SZ_LHU: sz = BUS_HALF;
        default:       sz = BUS_WORD;
      endcase
    end
    return sz;
  endfunction

  // Natural alignment check for a given bus size
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] addrLow);
    return ((sz == BUS_HALF) && addrLow[0]) ||
           ((sz == BUS_WORD) && (addrLow != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   SRAM-like data bus between the load/store unit (master) and memory
//   (slave). The master holds req and the request fields stable until
//   addr_ok; data_ok marks read data valid or write completion.
//   Signals:
//     data_req      master->slave  request valid
//     data_wr       master->slave  1 = store
//     data_size     master->slave  0 byte, 1 half, 2 word
//     data_wstrb    master->slave  byte enables (0 on loads)
//     data_addr     master->slave  byte address
//     data_wdata    master->slave  lane-replicated store data
//     data_addr_ok  slave->master  request accepted
//     data_data_ok  slave->master  data valid / write done
//     data_rdata    slave->master  read data
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// load_extend
//   Combinational load alignment: picks the addressed byte or halfword lane
//   out of the 32-bit read word and sign- or zero-extends it according to
//   the instruction size code. Word and unknown codes pass rdata through.
//   Ports:
//     rdata     in  32  raw bus read data
//     addrLow   in  2   address bits [1:0] of the access
//     sizeCode  in  3   instrM[28:26] code of the load
//     loadData  out 32  aligned, extended result
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLow,
  input  logic [2:0]  sizeCode,
  output logic [31:0] loadData
);

  logic [7:0]  lanes [4];
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign selByte = lanes[addrLow];
  assign selHalf = addrLow[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    loadData = rdata;
    case (sizeCode)
      SZ_LB:   loadData = {{24{selByte[7]}}, selByte};
      SZ_LBU:  loadData = {24'b0, selByte};
      SZ_LH:   loadData = {{16{selHalf[15]}}, selHalf};
      SZ_LHU:  loadData = {16'b0, selHalf};
      default: loadData = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store unit. Decodes the access size from instrM,
//   flags misaligned loads/stores, runs one bus transaction per memory
//   instruction through an IDLE/REQ/WAIT/DONE FSM and returns the aligned,
//   extended load result. stall_req holds the pipeline until the access
//   has completed.
//   Optional feature: compile with LSU_KSEG_MAP_EN defined to map the
//   0x8000_0000-0xBFFF_FFFF window onto physical {3'b0, a[28:0]}.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     mem_readM, mem_writeM    load / store in M stage
//     instrM                   M-stage instruction (size code in [28:26])
//     aluoutM                  effective address
//     rt_valueM                store data
//     stallM, flushM           M stage held / flushed
//     bus                      data bus, master side
//     load_dataM               aligned, extended load result (held)
//     stall_req                access in progress
//     adelM, adesM, bad_addrM  address error flags and faulting address
//   Only ADDR_W = DATA_W = 32 is supported.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_readM,
  input  logic              mem_writeM,
  input  logic [31:0]       instrM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] rt_valueM,
  input  logic              stallM,
  input  logic              flushM,
  mem_access_unit_if.master bus,
  output logic [DATA_W-1:0] load_dataM,
  output logic              stall_req,
  output logic              adelM,
  output logic              adesM,
  output logic [ADDR_W-1:0] bad_addrM
);

  lsuStateT          stateReg, stateNext;
  logic              cancelReg, cancelNext;
  logic [ADDR_W-1:0] addrReg;
  logic [1:0]        sizeReg;
  logic              wrReg;
  logic [3:0]        wstrbReg;
  logic [DATA_W-1:0] wdataReg;
  logic [2:0]        codeReg;
  logic [DATA_W-1:0] loadDataReg;

  logic [2:0]        sizeCode;
  logic [1:0]        loadSize, storeSize, accessSize;
  logic              access;
  logic              issue;
  logic              capture;
  logic [DATA_W-1:0] storeData;
  logic [3:0]        storeStrb;
  logic [DATA_W-1:0] extData;
  logic              unusedBits;

  // ---------------------------------------------------------------- decode
  assign sizeCode   = instrM[28:26];
  assign unusedBits = ^{instrM[31:29], instrM[25:0]};
  assign loadSize   = busSize(sizeCode, 1'b0);
  assign storeSize  = busSize(sizeCode, 1'b1);
  assign accessSize = mem_writeM ? storeSize : loadSize;

  assign adelM     = mem_readM  & misaligned(loadSize,  aluoutM[1:0]);
  assign adesM     = mem_writeM & misaligned(storeSize, aluoutM[1:0]);
  assign bad_addrM = aluoutM;

  assign access = (mem_readM | mem_writeM) & ~adelM & ~adesM & ~flushM;

  // Store data is replicated into every lane so memory only needs wstrb
  always_comb begin
    storeData = rt_valueM;
    storeStrb = 4'b1111;
    case (storeSize)
      BUS_BYTE: begin
        storeData = {4{rt_valueM[7:0]}};
        storeStrb = 4'b0001 << aluoutM[1:0];
      end
      BUS_HALF: begin
        storeData = {2{rt_valueM[15:0]}};
        storeStrb = aluoutM[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= ST_IDLE;
      cancelReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cancelReg <= cancelNext;
    end
  end

  // A flush cannot withdraw a request that memory has not yet accepted, so
  // it is remembered in cancel and the response is drained and dropped.
  always_comb begin
    stateNext  = stateReg;
    cancelNext = cancelReg;
    issue      = 1'b0;
    capture    = 1'b0;
    case (stateReg)
      ST_IDLE: begin
        cancelNext = 1'b0;
        if (access) begin
          stateNext = ST_REQ;
          issue     = 1'b1;
        end
      end
      ST_REQ: begin
        cancelNext = cancelReg | flushM;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            if (cancelReg | flushM) begin
              stateNext  = ST_IDLE;
              cancelNext = 1'b0;
            end else begin
              stateNext = ST_DONE;
              capture   = ~wrReg;
            end
          end else begin
            stateNext = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cancelNext = cancelReg | flushM;
        if (bus.data_data_ok) begin
          if (cancelReg | flushM) begin
            stateNext  = ST_IDLE;
            cancelNext = 1'b0;
          end else begin
            stateNext = ST_DONE;
            capture   = ~wrReg;
          end
        end
      end
      ST_DONE: begin
        // Stay here while the stage is stalled so the access is not re-issued
        if (~stallM | flushM) begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- request / result regs
  always_ff @(posedge clk) begin
    if (rst) begin
      addrReg     <= '0;
      sizeReg     <= 2'd0;
      wrReg       <= 1'b0;
      wstrbReg    <= 4'd0;
      wdataReg    <= '0;
      codeReg     <= 3'd0;
      loadDataReg <= '0;
    end else begin
      if (issue) begin
        addrReg  <= aluoutM;
        sizeReg  <= accessSize;
        wrReg    <= mem_writeM;
        wstrbReg <= mem_writeM ? storeStrb : 4'd0;
        wdataReg <= mem_writeM ? storeData : '0;
        codeReg  <= sizeCode;
      end
      if (capture) begin
        loadDataReg <= extData;
      end
    end
  end

  load_extend uLoadExtend (
    .rdata    (bus.data_rdata),
    .addrLow  (addrReg[1:0]),
    .sizeCode (codeReg),
    .loadData (extData)
  );

  // ------------------------------------------------------------- outputs
  assign bus.data_req   = (stateReg == ST_REQ);
  assign bus.data_wr    = wrReg;
  assign bus.data_size  = sizeReg;
  assign bus.data_wstrb = wstrbReg;
  assign bus.data_wdata = wdataReg;

`ifdef LSU_KSEG_MAP_EN
  // Unmapped kernel segments (top bits 2'b10) alias physical low memory
  assign bus.data_addr = (addrReg[31:30] == 2'b10) ? {3'b000, addrReg[28:0]} : addrReg;
`else
  assign bus.data_addr = addrReg;
`endif

  assign load_dataM = loadDataReg;
  assign stall_req  = ((stateReg == ST_IDLE) & access) |
                      (stateReg == ST_REQ) | (stateReg == ST_WAIT);

endmodule
